mod_counter_n: RTL

//  Parametrised modulo counter, next generation of the 8-bit limit/load counter.

---
 rtl/mod_counter_n_pkg.sv | 13 +
 rtl/mod_counter_n_if.sv | 24 ++
 rtl/mod_counter_n_step.sv | 30 +++
 rtl/mod_counter_n.sv | 89 ++++++++
 4 files changed

// File: rtl/mod_counter_n_pkg.sv
// Shared encodings for the modulo counter: run modes and control FSM states.
package mod_counter_n_pkg;

    localparam logic [1:0] CNT_MODE_WRAP    = 2'b00;
    localparam logic [1:0] CNT_MODE_SAT     = 2'b01;
    localparam logic [1:0] CNT_MODE_ONESHOT = 2'b10;

    typedef enum logic {
        CNT_ST_RUN  = 1'b0,
        CNT_ST_HALT = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/mod_counter_n_if.sv
// Control and status bundle of the modulo counter.
interface mod_counter_n_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             up;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;

    modport master (
        output en, load, load_val, limit, up, mode,
        input  count, tc, done
    );

    modport slave (
        input  en, load, load_val, limit, up, mode,
        output count, tc, done
    );
endinterface

// File: rtl/mod_counter_n_step.sv
// Combinational step of the counter: terminal detection and next value for the active mode.
module cnt_step_unit
    import mod_counter_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] top,
    input  logic             up,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_count,
    output logic             term
);

    always_comb begin
        // Up-count uses >= so a raw load above top terminates on its first step.
        term       = up ? (count >= top) : (count == '0);
        next_count = count;
        if (!term) begin
            next_count = up ? count + WIDTH'(1) : count - WIDTH'(1);
        end else begin
            case (mode)
                CNT_MODE_SAT,
                CNT_MODE_ONESHOT: next_count = count;
                default:          next_count = up ? '0 : top;
            endcase
        end
    end

endmodule

// File: rtl/mod_counter_n.sv
// Modulo counter with wrap/saturate/one-shot modes, load override and terminal-count pulse.
module mod_counter_n
    import mod_counter_n_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic           clk,
    input logic           reset,
    mod_counter_n_if.slave bus
);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] step_count;
    logic             term;
    logic             term_evt;

    // limit==0 selects the full 2^WIDTH range.
    function automatic logic [WIDTH-1:0] calc_top(input logic [WIDTH-1:0] lim);
        return (lim == '0) ? '1 : lim - WIDTH'(1);
    endfunction

    assign top      = calc_top(bus.limit);
    assign term_evt = bus.en & ~bus.load & term & (state_q == CNT_ST_RUN);

    cnt_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .count      (count_q),
        .top        (top),
        .up         (bus.up),
        .mode       (bus.mode),
        .next_count (step_count),
        .term       (term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CNT_ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = CNT_ST_RUN;
        end else if (term_evt && bus.mode == CNT_MODE_ONESHOT) begin
            state_d = CNT_ST_HALT;
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = term_evt;
        done_d  = done_q;
        if (bus.load) begin
            count_d = bus.load_val;
            done_d  = 1'b0;
        end else if (bus.en && state_q == CNT_ST_RUN) begin
            count_d = step_count;
            if (term_evt && bus.mode == CNT_MODE_ONESHOT) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;

endmodule
